// File: rtl/register_file_mp.sv
// Multi-port CPU register file with a clear sequencer, an optional hard-wired zero register
// and optional same-cycle write-to-read bypass. Data lanes carry signed values as raw bits.
module register_file_mp #(
    parameter int RegisterWidth = 32,
    parameter int NRegisters    = 32,
    parameter int NReadPorts    = 2,
    parameter int NWritePorts   = 1,
    parameter int ZeroReg       = 1,
    parameter int Bypass        = 0,
    localparam int AddrWidth    = $clog2(NRegisters)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NReadPorts-1:0][AddrWidth-1:0]    rAddr,
    output logic [NReadPorts-1:0][RegisterWidth-1:0] rData,
    input  logic [NWritePorts-1:0]                  wEn,
    input  logic [NWritePorts-1:0][AddrWidth-1:0]   wAddr,
    input  logic [NWritePorts-1:0][RegisterWidth-1:0] wData,
    input  logic                                    clearReq,
    output logic                                    ready
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam logic [AddrWidth:0]   NRegLimit = (AddrWidth+1)'(NRegisters);
    localparam logic [AddrWidth-1:0] LastIdx   = AddrWidth'(NRegisters - 1);

    state_t                   state;
    logic [AddrWidth-1:0]     clearIdx;
    logic [RegisterWidth-1:0] regs [NRegisters];
    logic                     active;

    function automatic logic addr_valid(input logic [AddrWidth-1:0] a);
        return {1'b0, a} < NRegLimit;
    endfunction

    function automatic logic addr_writable(input logic [AddrWidth-1:0] a);
        return addr_valid(a) && !((ZeroReg != 0) && (a == '0));
    endfunction

    assign active = (state == READY) && !reset;
    assign ready  = active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clearIdx <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clearIdx == LastIdx) begin
                        state <= READY;
                    end else begin
                        clearIdx <= clearIdx + 1'b1;
                    end
                end
                READY: begin
                    if (clearReq) begin
                        state    <= CLEAR;
                        clearIdx <= '0;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clearIdx <= '0;
                end
            endcase
        end
    end

    // Ascending port order lets the highest-numbered port win on an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clearIdx] <= '0;
            end else begin
                for (int unsigned p = 0; p < NWritePorts; p++) begin
                    if (wEn[p] && addr_writable(wAddr[p])) begin
                        regs[wAddr[p]] <= wData[p];
                    end
                end
            end
        end
    end

    always_comb begin
        rData = '0;
        for (int unsigned i = 0; i < NReadPorts; i++) begin
            if (active && addr_writable(rAddr[i])) begin
                rData[i] = regs[rAddr[i]];
                if (Bypass != 0) begin
                    for (int unsigned p = 0; p < NWritePorts; p++) begin
                        if (wEn[p] && addr_writable(wAddr[p]) && (wAddr[p] == rAddr[i])) begin
                            rData[i] = wData[p];
                        end
                    end
                end
            end
        end
    end

endmodule
